// File: rtl/pipe_pkg.sv
// pipe_pkg: shared types for the decode->execute pipeline register.
//   pipe_state_t : occupancy state of the stage (EMPTY, FULL, SKID)
//   de_payload_t : one instruction's control bundle plus operands, default widths
//   CTRL_*       : bit offsets execute uses to unpack the control bundle
package pipe_pkg;

  localparam int unsigned PIPE_DATA_WIDTH     = 32;
  localparam int unsigned PIPE_CTRL_WIDTH     = 16;
  localparam int unsigned PIPE_REG_ADDR_WIDTH = 5;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL  = 2'd1,
    SKID  = 2'd2
  } pipe_state_t;

  typedef struct packed {
    logic [PIPE_CTRL_WIDTH-1:0]     ctrl;
    logic [PIPE_DATA_WIDTH-1:0]     pc;
    logic [PIPE_DATA_WIDTH-1:0]     rd1;
    logic [PIPE_DATA_WIDTH-1:0]     rd2;
    logic [PIPE_DATA_WIDTH-1:0]     imm;
    logic [PIPE_REG_ADDR_WIDTH-1:0] rd;
  } de_payload_t;

  // Control bundle layout (LSB first).
  localparam int unsigned CTRL_REGWRITE_BIT  = 0;
  localparam int unsigned CTRL_RESULTSRC_LSB = 1;  // 2 bits
  localparam int unsigned CTRL_MEMWRITE_BIT  = 3;
  localparam int unsigned CTRL_BRANCH_BIT    = 4;
  localparam int unsigned CTRL_BRANCHSRC_BIT = 5;
  localparam int unsigned CTRL_ALUSRC_BIT    = 6;
  localparam int unsigned CTRL_ALUCTRL_LSB   = 7;  // 4 bits
  localparam int unsigned CTRL_JUMP_BIT      = 11;
  localparam int unsigned CTRL_JALR_BIT      = 12;

endpackage

// File: rtl/pipe_skid_slot.sv
// pipe_skid_slot: one enable-loaded payload register, cleared by async reset.
//   clk, rst : clock, asynchronous active-high reset
//   i_load   : capture i_d on the next rising edge
//   i_d      : flattened payload in
//   o_q      : stored payload
module pipe_skid_slot #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_q <= '0;
    end else if (i_load) begin
      r_q <= i_d;
    end
  end

  assign o_q = r_q;

endmodule

// File: rtl/decode_exec_pipe.sv
// decode_exec_pipe: valid/ready pipeline register between decode and execute.
// Optional feature macro: DECODE_EXEC_PIPE_SKID_EN adds a skid slot so readyD_o is
// registered; without it readyD_o = readyE_i || !validE_o (combinational).
//   clk, rst                     : clock, asynchronous active-high reset
//   flush_i                      : squash held and offered instructions
//   validD_i / readyD_o          : decode-side handshake
//   ctrlD_i, PCD_i, RD1D_i,
//   RD2D_i, ImmExtD_i, rdD_i     : decode-side payload
//   validE_o / readyE_i          : execute-side handshake
//   ctrlE_o (zero when invalid),
//   PCE_o, RD1E_o, RD2E_o,
//   ImmExtE_o, rdE_o             : execute-side payload
module decode_exec_pipe
  import pipe_pkg::*;
#(
  parameter int unsigned DATA_WIDTH     = 32,
  parameter int unsigned CTRL_WIDTH     = 16,
  parameter int unsigned REG_ADDR_WIDTH = 5
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      flush_i,
  input  logic                      validD_i,
  output logic                      readyD_o,
  input  logic [CTRL_WIDTH-1:0]     ctrlD_i,
  input  logic [DATA_WIDTH-1:0]     PCD_i,
  input  logic [DATA_WIDTH-1:0]     RD1D_i,
  input  logic [DATA_WIDTH-1:0]     RD2D_i,
  input  logic [DATA_WIDTH-1:0]     ImmExtD_i,
  input  logic [REG_ADDR_WIDTH-1:0] rdD_i,
  output logic                      validE_o,
  input  logic                      readyE_i,
  output logic [CTRL_WIDTH-1:0]     ctrlE_o,
  output logic [DATA_WIDTH-1:0]     PCE_o,
  output logic [DATA_WIDTH-1:0]     RD1E_o,
  output logic [DATA_WIDTH-1:0]     RD2E_o,
  output logic [DATA_WIDTH-1:0]     ImmExtE_o,
  output logic [REG_ADDR_WIDTH-1:0] rdE_o
);

  localparam int unsigned PayloadW = CTRL_WIDTH + 4 * DATA_WIDTH + REG_ADDR_WIDTH;

  pipe_state_t         r_state;
  pipe_state_t         w_state_d;
  logic                w_main_load;
  logic [PayloadW-1:0] w_in_payload;
  logic [PayloadW-1:0] w_main_d;
  logic [PayloadW-1:0] w_main_q;
  logic [CTRL_WIDTH-1:0] w_ctrl_q;

  assign w_in_payload = {ctrlD_i, PCD_i, RD1D_i, RD2D_i, ImmExtD_i, rdD_i};
  assign validE_o     = (r_state != EMPTY);

`ifdef DECODE_EXEC_PIPE_SKID_EN
  logic                w_skid_load;
  logic [PayloadW-1:0] w_skid_q;

  assign readyD_o = (r_state != SKID);

  always_comb begin
    w_state_d   = r_state;
    w_main_load = 1'b0;
    w_skid_load = 1'b0;
    w_main_d    = w_in_payload;
    if (flush_i) begin
      // Offered instruction is swallowed; an out-transfer this cycle still completes.
      w_state_d = EMPTY;
    end else begin
      case (r_state)
        EMPTY: begin
          if (validD_i) begin
            w_main_load = 1'b1;
            w_state_d   = FULL;
          end
        end
        FULL: begin
          if (readyE_i) begin
            if (validD_i) begin
              w_main_load = 1'b1;
            end else begin
              w_state_d = EMPTY;
            end
          end else if (validD_i) begin
            w_skid_load = 1'b1;
            w_state_d   = SKID;
          end
        end
        SKID: begin
          if (readyE_i) begin
            w_main_d    = w_skid_q;
            w_main_load = 1'b1;
            w_state_d   = FULL;
          end
        end
        default: w_state_d = EMPTY;
      endcase
    end
  end

  pipe_skid_slot #(
    .WIDTH (PayloadW)
  ) u_skid (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_skid_load),
    .i_d    (w_in_payload),
    .o_q    (w_skid_q)
  );
`else
  assign readyD_o = readyE_i || !validE_o;

  always_comb begin
    w_state_d   = r_state;
    w_main_load = 1'b0;
    w_main_d    = w_in_payload;
    if (flush_i) begin
      w_state_d = EMPTY;
    end else begin
      case (r_state)
        EMPTY: begin
          if (validD_i) begin
            w_main_load = 1'b1;
            w_state_d   = FULL;
          end
        end
        FULL: begin
          if (readyE_i) begin
            if (validD_i) begin
              w_main_load = 1'b1;
            end else begin
              w_state_d = EMPTY;
            end
          end
        end
        default: w_state_d = EMPTY;
      endcase
    end
  end
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= EMPTY;
    end else begin
      r_state <= w_state_d;
    end
  end

  pipe_skid_slot #(
    .WIDTH (PayloadW)
  ) u_main (
    .clk    (clk),
    .rst    (rst),
    .i_load (w_main_load),
    .i_d    (w_main_d),
    .o_q    (w_main_q)
  );

  assign {w_ctrl_q, PCE_o, RD1E_o, RD2E_o, ImmExtE_o, rdE_o} = w_main_q;

  // Bubbles must never carry memWrite/branch/regWrite into execute.
  assign ctrlE_o = validE_o ? w_ctrl_q : '0;

endmodule

// File: tb/tb_decode_exec_pipe.sv
module tb_decode_exec_pipe;
  import pipe_pkg::*;

`ifdef DECODE_EXEC_PIPE_SKID_EN
  localparam bit SkidEn = 1'b1;
`else
  localparam bit SkidEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush_i = 1'b0;
  logic        validD_i = 1'b0;
  logic        readyD_o;
  logic [15:0] ctrlD_i = '0;
  logic [31:0] PCD_i = '0, RD1D_i = '0, RD2D_i = '0, ImmExtD_i = '0;
  logic [4:0]  rdD_i = '0;
  logic        validE_o;
  logic        readyE_i = 1'b0;
  logic [15:0] ctrlE_o;
  logic [31:0] PCE_o, RD1E_o, RD2E_o, ImmExtE_o;
  logic [4:0]  rdE_o;

  int checks = 0;
  int errors = 0;

  // Reference model: an in-order queue of accepted, not yet consumed instructions.
  de_payload_t q[$];

  always #5 clk = ~clk;

  decode_exec_pipe #(
    .DATA_WIDTH     (32),
    .CTRL_WIDTH     (16),
    .REG_ADDR_WIDTH (5)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .flush_i   (flush_i),
    .validD_i  (validD_i),
    .readyD_o  (readyD_o),
    .ctrlD_i   (ctrlD_i),
    .PCD_i     (PCD_i),
    .RD1D_i    (RD1D_i),
    .RD2D_i    (RD2D_i),
    .ImmExtD_i (ImmExtD_i),
    .rdD_i     (rdD_i),
    .validE_o  (validE_o),
    .readyE_i  (readyE_i),
    .ctrlE_o   (ctrlE_o),
    .PCE_o     (PCE_o),
    .RD1E_o    (RD1E_o),
    .RD2E_o    (RD2E_o),
    .ImmExtE_o (ImmExtE_o),
    .rdE_o     (rdE_o)
  );

  // Stage capacity is 2 with the skid slot, else 1 with pass-through readiness.
  function automatic bit model_ready();
    if (SkidEn) return q.size() < 2;
    return (q.size() == 0) || readyE_i;
  endfunction

  function automatic de_payload_t mk_item(input logic [31:0] pc, input logic [15:0] ctrl);
    de_payload_t it;
    it.ctrl = ctrl;
    it.pc   = pc;
    it.rd1  = $urandom;
    it.rd2  = $urandom;
    it.imm  = $urandom;
    it.rd   = 5'($urandom_range(0, 31));
    return it;
  endfunction

  task automatic offer(input bit vd, input bit re, input bit fl, input de_payload_t it);
    validD_i  = vd;
    readyE_i  = re;
    flush_i   = fl;
    ctrlD_i   = it.ctrl;
    PCD_i     = it.pc;
    RD1D_i    = it.rd1;
    RD2D_i    = it.rd2;
    ImmExtD_i = it.imm;
    rdD_i     = it.rd;
    #1;
  endtask

  task automatic tick();
    bit do_out, do_in;
    @(posedge clk);
    if (!rst) begin
      do_out = (q.size() > 0) && readyE_i;
      do_in  = validD_i && model_ready();
      if (flush_i) begin
        q.delete();
      end else begin
        if (do_out) void'(q.pop_front());
        if (do_in) q.push_back('{ctrl: ctrlD_i, pc: PCD_i, rd1: RD1D_i, rd2: RD2D_i,
                                 imm: ImmExtD_i, rd: rdD_i});
      end
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    checks++;
    if (readyD_o !== 1'b1 || validE_o !== 1'b0 || ctrlE_o !== 16'h0 || PCE_o !== 32'h0) begin
      errors++;
      $display("FAIL reset_idle: readyD=%b validE=%b ctrlE=%h PCE=%h, want 1 0 0000 00000000",
               readyD_o, validE_o, ctrlE_o, PCE_o);
    end
    offer(1, 1, 0, mk_item(32'h40, 16'hA5A5));
    tick();
    offer(0, 0, 0, mk_item(32'h0, 16'h0));
    checks++;
    if (validE_o !== 1'b1 || PCE_o !== 32'h40) begin
      errors++;
      $display("FAIL reset_preload: validE=%b PCE=%h, want 1 00000040", validE_o, PCE_o);
    end
    #2 rst = 1'b1;
    #1;
    checks++;
    if (validE_o !== 1'b0 || ctrlE_o !== 16'h0 || PCE_o !== 32'h0 || readyD_o !== 1'b1) begin
      errors++;
      $display("FAIL reset_async: validE=%b ctrlE=%h PCE=%h readyD=%b, want 0 0000 0 1",
               validE_o, ctrlE_o, PCE_o, readyD_o);
    end
    q.delete();
    tick();
    rst = 1'b0;
    #1;
    checks++;
    if (readyD_o !== 1'b1 || validE_o !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: readyD=%b validE=%b, want 1 0", readyD_o, validE_o);
    end
  endtask

  task automatic test_streaming();
    de_payload_t items[3];
    for (int k = 0; k < 3; k++) items[k] = mk_item(32'(4 * k), 16'(16'h0101 * (k + 1)));
    for (int k = 0; k < 4; k++) begin
      if (k < 3) offer(1, 1, 0, items[k]);
      else offer(0, 1, 0, items[0]);
      checks++;
      if (readyD_o !== 1'b1) begin
        errors++;
        $display("FAIL stream_ready[%0d]: readyD=%b, want 1", k, readyD_o);
      end
      if (k > 0) begin
        checks++;
        if (validE_o !== 1'b1 || PCE_o !== items[k-1].pc || ctrlE_o !== items[k-1].ctrl ||
            RD1E_o !== items[k-1].rd1 || rdE_o !== items[k-1].rd) begin
          errors++;
          $display("FAIL stream_out[%0d]: validE=%b PCE=%h ctrlE=%h, want 1 %h %h", k,
                   validE_o, PCE_o, ctrlE_o, items[k-1].pc, items[k-1].ctrl);
        end
      end
      tick();
    end
    offer(0, 1, 0, items[0]);
    checks++;
    if (validE_o !== 1'b0) begin
      errors++;
      $display("FAIL stream_drain: validE=%b, want 0", validE_o);
    end
  endtask

  task automatic test_stall_skid();
    de_payload_t i4, i8;
    bit pending, acc;
    i4 = mk_item(32'h04, 16'h1234);
    i8 = mk_item(32'h08, 16'h5678);
    offer(1, 1, 0, i4);
    tick();
    pending = 1'b1;
    offer(pending, 0, 0, i8);
    acc = pending && model_ready();
    tick();
    pending = pending && !acc;
    offer(pending, 0, 0, i8);
    checks++;
    if (readyD_o !== 1'b0 || validE_o !== 1'b1 || PCE_o !== 32'h04) begin
      errors++;
      $display("FAIL stall_hold: readyD=%b validE=%b PCE=%h, want 0 1 00000004",
               readyD_o, validE_o, PCE_o);
    end
    acc = pending && model_ready();
    tick();
    pending = pending && !acc;
    offer(pending, 1, 0, i8);
    checks++;
    if (validE_o !== 1'b1 || PCE_o !== 32'h04) begin
      errors++;
      $display("FAIL stall_first: validE=%b PCE=%h, want 1 00000004", validE_o, PCE_o);
    end
    acc = pending && model_ready();
    tick();
    pending = pending && !acc;
    offer(pending, 1, 0, i8);
    checks++;
    if (pending || validE_o !== 1'b1 || PCE_o !== 32'h08 || ctrlE_o !== 16'h5678) begin
      errors++;
      $display("FAIL stall_second: validE=%b PCE=%h ctrlE=%h pending=%b, want 1 00000008 5678 0",
               validE_o, PCE_o, ctrlE_o, pending);
    end
    tick();
    offer(0, 1, 0, i8);
    checks++;
    if (validE_o !== 1'b0 || readyD_o !== 1'b1) begin
      errors++;
      $display("FAIL stall_drain: validE=%b readyD=%b, want 0 1", validE_o, readyD_o);
    end
  endtask

  task automatic test_flush();
    offer(1, 1, 0, mk_item(32'h10, 16'h00F1));
    tick();
    offer(1, 0, 0, mk_item(32'h14, 16'h00F2));
    tick();
    offer(1, 0, 1, mk_item(32'h18, 16'h00F3));
    tick();
    offer(0, 1, 0, mk_item(32'h0, 16'h0));
    checks++;
    if (validE_o !== 1'b0 || ctrlE_o !== 16'h0 || readyD_o !== 1'b1) begin
      errors++;
      $display("FAIL flush_after: validE=%b ctrlE=%h readyD=%b, want 0 0000 1",
               validE_o, ctrlE_o, readyD_o);
    end
    for (int k = 0; k < 4; k++) begin
      tick();
      offer(0, 1, 0, mk_item(32'h0, 16'h0));
      checks++;
      if (validE_o !== 1'b0) begin
        errors++;
        $display("FAIL flush_ghost[%0d]: validE=%b PCE=%h, want validE 0", k, validE_o, PCE_o);
      end
    end
  endtask

  task automatic test_bubble();
    for (int k = 0; k < 6; k++) begin
      offer(0, 1'($urandom_range(0, 1)), 0, mk_item(32'h100, 16'hFFFF));
      checks++;
      if (ctrlE_o !== 16'h0 || validE_o !== 1'b0) begin
        errors++;
        $display("FAIL bubble_idle[%0d]: ctrlE=%h validE=%b, want 0000 0", k, ctrlE_o, validE_o);
      end
      tick();
    end
    offer(1, 1, 0, mk_item(32'h104, 16'hFFFF));
    tick();
    offer(0, 1, 0, mk_item(32'h108, 16'hFFFF));
    checks++;
    if (ctrlE_o !== 16'hFFFF || validE_o !== 1'b1) begin
      errors++;
      $display("FAIL bubble_valid: ctrlE=%h validE=%b, want ffff 1", ctrlE_o, validE_o);
    end
    tick();
    offer(0, 1, 0, mk_item(32'h10C, 16'hFFFF));
    checks++;
    if (ctrlE_o !== 16'h0 || validE_o !== 1'b0) begin
      errors++;
      $display("FAIL bubble_after: ctrlE=%h validE=%b, want 0000 0", ctrlE_o, validE_o);
    end
    tick();
  endtask

  task automatic test_random();
    logic [31:0] pc = 32'h1000;
    bit vd, re, fl;
    for (int n = 0; n < 400; n++) begin
      vd = ($urandom_range(0, 3) != 0);
      re = ($urandom_range(0, 2) != 0);
      fl = ($urandom_range(0, 19) == 0);
      offer(vd, re, fl, mk_item(pc, 16'($urandom)));
      checks++;
      if (validE_o !== (q.size() > 0) || readyD_o !== model_ready()) begin
        errors++;
        $display("FAIL rand_hs[%0d]: validE=%b readyD=%b, want %b %b", n, validE_o, readyD_o,
                 q.size() > 0, model_ready());
      end
      checks++;
      if (q.size() > 0) begin
        if (ctrlE_o !== q[0].ctrl || PCE_o !== q[0].pc || RD1E_o !== q[0].rd1 ||
            RD2E_o !== q[0].rd2 || ImmExtE_o !== q[0].imm || rdE_o !== q[0].rd) begin
          errors++;
          $display("FAIL rand_data[%0d]: PCE=%h ctrlE=%h rdE=%0d, want %h %h %0d", n, PCE_o,
                   ctrlE_o, rdE_o, q[0].pc, q[0].ctrl, q[0].rd);
        end
      end else if (ctrlE_o !== 16'h0) begin
        errors++;
        $display("FAIL rand_bubble[%0d]: ctrlE=%h, want 0000", n, ctrlE_o);
      end
      if (vd && model_ready()) pc = pc + 32'd4;
      tick();
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    test_reset();
    test_streaming();
    test_stall_skid();
    test_flush();
    test_bubble();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
